// File: rtl/mem_port_16b_if.sv
// mem_port_16b_if: request side (ALU/register bank) and 8-bit external req/ack bus of the load/store port.
interface mem_port_16b_if;
   logic        start;
   logic        wr;
   logic        wide;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] t16;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_we;
   logic        bus_req;
   logic [7:0]  bus_rdata;
   logic        bus_ack;
   modport master (
      input  start, wr, wide, addr, wdata, bus_rdata, bus_ack,
      output busy, done, err, t16, bus_addr, bus_wdata, bus_we, bus_req
   );
   modport slave (
      output start, wr, wide, addr, wdata, bus_rdata, bus_ack,
      input  busy, done, err, t16, bus_addr, bus_wdata, bus_we, bus_req
   );
endinterface

// File: rtl/mem_port_16b.sv
// mem_port_16b: load/store stage splitting 8/16-bit accesses into little-endian byte cycles on a req/ack bus.
// MEM_PAGE_WRAP_EN keeps the second byte of a wide access inside the first byte's 256-byte page.
module mem_port_16b #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic clk,
   input logic rst,
   mem_port_16b_if.master m
);
   typedef enum logic [1:0] {IDLE, B0, GAP, B1} state_t;
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic wide_q, wide_n, busy_n, done_n, err_n, req_n, we_n, tmo;
   logic [7:0] hi_q, hi_n, wd_n;
   logic [15:0] t16_n, addr_n, addr2;
`ifdef MEM_PAGE_WRAP_EN
   assign addr2 = {m.bus_addr[15:8], m.bus_addr[7:0] + 8'h01};
`else
   assign addr2 = m.bus_addr + 16'h0001;
`endif
   // abort on the edge that would complete the TIMEOUT_CYCLES-th unacknowledged cycle
   assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == TLIM);
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      wide_n = wide_q;
      hi_n = hi_q;
      done_n = 1'b0;
      err_n = 1'b0;
      req_n = m.bus_req;
      we_n = m.bus_we;
      addr_n = m.bus_addr;
      wd_n = m.bus_wdata;
      t16_n = m.t16;
      case (state)
         IDLE: if (m.start) begin
            state_n = B0;
            wide_n = m.wide;
            hi_n = m.wdata[15:8];
            addr_n = m.addr;
            we_n = m.wr;
            wd_n = m.wdata[7:0];
            req_n = 1'b1;
            cnt_n = '0;
         end
         B0, B1: if (m.bus_ack) begin
            if (!m.bus_we)
               t16_n = (state == B1) ? {m.bus_rdata, m.t16[7:0]} :
                       wide_q ? {m.t16[15:8], m.bus_rdata} : {8'h00, m.bus_rdata};
            req_n = 1'b0;
            done_n = (state == B1) || !wide_q;
            state_n = done_n ? IDLE : GAP;
         end else if (tmo) begin
            req_n = 1'b0;
            done_n = 1'b1;
            err_n = 1'b1;
            state_n = IDLE;
         end else begin
            cnt_n = cnt + 1'b1;
         end
         GAP: begin
            state_n = B1;
            addr_n = addr2;
            wd_n = hi_q;
            req_n = 1'b1;
            cnt_n = '0;
         end
         default: state_n = IDLE;
      endcase
      busy_n = state_n != IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         wide_q <= 1'b0;
         hi_q <= '0;
         m.busy <= 1'b0;
         m.done <= 1'b0;
         m.err <= 1'b0;
         m.bus_req <= 1'b0;
         m.bus_we <= 1'b0;
         m.bus_addr <= '0;
         m.bus_wdata <= '0;
         m.t16 <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         wide_q <= wide_n;
         hi_q <= hi_n;
         m.busy <= busy_n;
         m.done <= done_n;
         m.err <= err_n;
         m.bus_req <= req_n;
         m.bus_we <= we_n;
         m.bus_addr <= addr_n;
         m.bus_wdata <= wd_n;
         m.t16 <= t16_n;
      end
   end
endmodule

// File: tb/tb_mem_port_16b.sv
// tb_mem_port_16b: directed and randomized load/store transactions against a byte-level reference model.
module tb_mem_port_16b;
   localparam int TO = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int passed = 0;
   logic [15:0] exp_t16 = '0;
   mem_port_16b_if bus ();
   mem_port_16b #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .m(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", tag, act, exp);
   endtask
   function automatic logic [15:0] second(input logic [15:0] a);
`ifdef MEM_PAGE_WRAP_EN
      second = {a[15:8], a[7:0] + 8'h01};
`else
      second = a + 16'h0001;
`endif
   endfunction
   // Called one time unit after an edge; leaves the bench in the done cycle so the next call starts there.
   task automatic txn(input logic w, input logic wd, input logic [15:0] a, input logic [15:0] d,
                      input int w0, input int w1, input logic [7:0] r0, input logic [7:0] r1,
                      input logic poke);
      int nb;
      int ws;
      logic [7:0] r;
      logic [15:0] ea;
      nb = wd ? 2 : 1;
      bus.start = 1'b1; bus.wr = w; bus.wide = wd; bus.addr = a; bus.wdata = d;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int b = 0; b < nb; b++) begin
         ws = (b != 0) ? w1 : w0;
         r = (b != 0) ? r1 : r0;
         ea = (b != 0) ? second(a) : a;
         check("req_high", {15'd0, bus.bus_req}, 16'd1);
         check("busy_high", {15'd0, bus.busy}, 16'd1);
         check("done_low", {15'd0, bus.done}, 16'd0);
         check("bus_addr", bus.bus_addr, ea);
         check("bus_we", {15'd0, bus.bus_we}, {15'd0, w});
         check("bus_wdata", {8'd0, bus.bus_wdata}, {8'd0, (b != 0) ? d[15:8] : d[7:0]});
         for (int k = 0; k < ws && k < TO; k++) begin
            if (poke) begin bus.start = 1'($urandom % 2); bus.addr = 16'h3000; end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (k == TO - 1) begin
               check("to_done", {15'd0, bus.done}, 16'd1);
               check("to_err", {15'd0, bus.err}, 16'd1);
               check("to_req", {15'd0, bus.bus_req}, 16'd0);
               check("to_busy", {15'd0, bus.busy}, 16'd0);
               check("to_t16", bus.t16, exp_t16);
               return;
            end
            check("wait_req", {15'd0, bus.bus_req}, 16'd1);
            check("wait_addr", bus.bus_addr, ea);
         end
         bus.bus_ack = 1'b1; bus.bus_rdata = r;
         @(posedge clk); #1;
         bus.bus_ack = 1'b0; bus.bus_rdata = 8'($urandom);
         if (!w) exp_t16 = !wd ? {8'h00, r} : (b != 0) ? {r, exp_t16[7:0]} : {exp_t16[15:8], r};
         check("ack_req_drop", {15'd0, bus.bus_req}, 16'd0);
         check("err_low", {15'd0, bus.err}, 16'd0);
         check("t16", bus.t16, exp_t16);
         if (b == nb - 1) begin
            check("done", {15'd0, bus.done}, 16'd1);
            check("busy_done", {15'd0, bus.busy}, 16'd0);
         end else begin
            check("gap_done", {15'd0, bus.done}, 16'd0);
            check("gap_busy", {15'd0, bus.busy}, 16'd1);
            bus.bus_ack = 1'($urandom % 2);
            @(posedge clk); #1;
            bus.bus_ack = 1'b0;
         end
      end
   endtask
   initial begin
      int ww;
      bus.start = 1'b0; bus.wr = 1'b0; bus.wide = 1'b0; bus.addr = '0; bus.wdata = '0;
      bus.bus_ack = 1'b0; bus.bus_rdata = '0;
      #1;
      check("rst_busy", {15'd0, bus.busy}, 16'd0);
      check("rst_done", {15'd0, bus.done}, 16'd0);
      check("rst_err", {15'd0, bus.err}, 16'd0);
      check("rst_req", {15'd0, bus.bus_req}, 16'd0);
      check("rst_we", {15'd0, bus.bus_we}, 16'd0);
      check("rst_t16", bus.t16, 16'd0);
      check("rst_addr", bus.bus_addr, 16'd0);
      check("rst_wdata", {8'd0, bus.bus_wdata}, 16'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      txn(1'b0, 1'b0, 16'h1234, 16'h0000, 0, 0, 8'hA5, 8'h00, 1'b0);
      txn(1'b0, 1'b1, 16'h2000, 16'h0000, 2, 0, 8'h34, 8'h12, 1'b1);
      txn(1'b1, 1'b1, 16'h12FF, 16'hBEEF, 0, 0, 8'h00, 8'h00, 1'b0);
      txn(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 1, 1, 8'h00, 8'h00, 1'b0);
      txn(1'b0, 1'b1, 16'h4000, 16'h0000, 0, 0, 8'h55, 8'h55, 1'b0);
      txn(1'b0, 1'b1, 16'h4002, 16'h0000, 0, 9, 8'h77, 8'h00, 1'b0);
      // asynchronous reset in the middle of a wide load's first byte cycle
      bus.start = 1'b1; bus.wr = 1'b0; bus.wide = 1'b1; bus.addr = 16'h5000;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("mid_req", {15'd0, bus.bus_req}, 16'd1);
      #2 rst = 1'b1;
      #1;
      exp_t16 = '0;
      check("arst_req", {15'd0, bus.bus_req}, 16'd0);
      check("arst_busy", {15'd0, bus.busy}, 16'd0);
      check("arst_done", {15'd0, bus.done}, 16'd0);
      check("arst_t16", bus.t16, exp_t16);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      txn(1'b0, 1'b0, 16'h0010, 16'h0000, 1, 0, 8'h3C, 8'h00, 1'b0);
      repeat (150) begin
         ww = ($urandom % 8 == 0) ? 4 + int'($urandom % 3) : int'($urandom % 4);
         txn(1'($urandom % 2), 1'($urandom % 2), 16'($urandom), 16'($urandom),
             int'($urandom % 4), ww, 8'($urandom), 8'($urandom), 1'($urandom % 2));
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
